// File: rtl/flex_stp_word_sr.sv
// Serial-to-parallel shift register with multi-bit lanes, beat counting and a valid/ack word holder.
// Optional STP_PARITY_EN adds a trailing even-parity beat per word and a parity_err output.
module flex_stp_word_sr #(
    parameter  int NUM_BITS   = 8,
    parameter  int LANE_WIDTH = 1,
    parameter  int SHIFT_MSB  = 1,
    parameter  int RESET_VAL  = 1,
    localparam int BEATS      = NUM_BITS / LANE_WIDTH,
    localparam int CW         = $clog2(BEATS + 2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  shift_enable,
    input  logic [LANE_WIDTH-1:0] serial_in,
    input  logic                  word_ack,
    output logic [NUM_BITS-1:0]   parallel_out,
    output logic [CW-1:0]         fill_count,
    output logic [NUM_BITS-1:0]   word_out,
    output logic                  word_valid,
    output logic                  overrun
`ifdef STP_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

`ifdef STP_PARITY_EN
    localparam int FRAME = BEATS + 1;
`else
    localparam int FRAME = BEATS;
`endif

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} hold_t;

    hold_t                state, state_next;
    logic [NUM_BITS-1:0]  sr, sr_shifted, word_next;
    logic                 data_beat, done, load, set_ovr;

    generate
        if (LANE_WIDTH == NUM_BITS) begin : g_full_lane
            assign sr_shifted = serial_in;
        end else if (SHIFT_MSB != 0) begin : g_to_msb
            assign sr_shifted = {sr[NUM_BITS-LANE_WIDTH-1:0], serial_in};
        end else begin : g_to_lsb
            assign sr_shifted = {serial_in, sr[NUM_BITS-1:LANE_WIDTH]};
        end
    endgenerate

    // The completed word is the post-shift value; a parity beat leaves sr untouched.
    always_comb begin
        done = shift_enable && (fill_count == CW'(FRAME - 1));
`ifdef STP_PARITY_EN
        data_beat = shift_enable && (fill_count != CW'(BEATS));
`else
        data_beat = shift_enable;
`endif
        word_next = data_beat ? sr_shifted : sr;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        set_ovr    = 1'b0;
        case (state)
            EMPTY: begin
                if (done) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (done && word_ack) begin
                    load = 1'b1;
                end else if (done) begin
                    set_ovr = 1'b1;
                end else if (word_ack) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) state <= EMPTY;
        else              state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= {NUM_BITS{1'(RESET_VAL)}};
            fill_count <= '0;
            word_out   <= '0;
            overrun    <= 1'b0;
`ifdef STP_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (clear) begin
            // word_out deliberately survives a clear
            sr         <= {NUM_BITS{1'(RESET_VAL)}};
            fill_count <= '0;
            overrun    <= 1'b0;
`ifdef STP_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (data_beat) sr <= sr_shifted;
            if (shift_enable) fill_count <= done ? '0 : fill_count + CW'(1);
            if (load) begin
                word_out <= word_next;
`ifdef STP_PARITY_EN
                parity_err <= (^word_next) ^ serial_in[0];
`endif
            end
            if (set_ovr) overrun <= 1'b1;
        end
    end

    assign parallel_out = sr;
    assign word_valid   = (state == FULL);

endmodule

// File: tb/tb_flex_stp_word_sr.sv
// Bench for flex_stp_word_sr: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_flex_stp_word_sr;
`ifdef STP_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int B1 = 8, F1 = B1 + PAR, B2 = 4, F2 = B2 + PAR;

    logic       clk = 1'b0;
    logic       rst, clear, se, ack, se2;
    logic [0:0] sin;
    logic [1:0] sin2;
    logic [7:0] po, wo, po2, wo2;
    logic [3:0] fc;
    logic [2:0] fc2;
    logic       wv, ovr, wv2, ovr2;
`ifdef STP_PARITY_EN
    logic       perr, perr2;
    bit         m_perr;
`endif

    int checks = 0, errors = 0;
    int m_sr, m_wo, m_cnt;
    bit m_wv, m_ovr;

    flex_stp_word_sr #(.NUM_BITS(8), .LANE_WIDTH(1), .SHIFT_MSB(1), .RESET_VAL(1)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .shift_enable(se), .serial_in(sin),
        .word_ack(ack), .parallel_out(po), .fill_count(fc), .word_out(wo),
        .word_valid(wv),
`ifdef STP_PARITY_EN
        .parity_err(perr),
`endif
        .overrun(ovr));

    flex_stp_word_sr #(.NUM_BITS(8), .LANE_WIDTH(2), .SHIFT_MSB(0), .RESET_VAL(1)) u_dut2 (
        .clk(clk), .rst(rst), .clear(clear), .shift_enable(se2), .serial_in(sin2),
        .word_ack(1'b0), .parallel_out(po2), .fill_count(fc2), .word_out(wo2),
        .word_valid(wv2),
`ifdef STP_PARITY_EN
        .parity_err(perr2),
`endif
        .overrun(ovr2));

    always #5 clk = ~clk;

    // One clock: drive inputs, advance the model of u_dut, sample 1ns after the edge.
    task automatic cycle(input bit r, input bit c, input bit s, input bit d, input bit a,
                         input bit s2, input logic [1:0] d2);
        bit done;
        rst = r; clear = c; se = s; sin = d; ack = a; se2 = s2; sin2 = d2;
        if (r) begin
            m_sr = 255; m_cnt = 0; m_wo = 0; m_wv = 0; m_ovr = 0;
`ifdef STP_PARITY_EN
            m_perr = 0;
`endif
        end else if (c) begin
            m_sr = 255; m_cnt = 0; m_wv = 0; m_ovr = 0;
`ifdef STP_PARITY_EN
            m_perr = 0;
`endif
        end else begin
            done = 0;
            if (s) begin
                if (m_cnt < B1) m_sr = (m_sr * 2 + int'(d)) % 256;
                m_cnt++;
                if (m_cnt == F1) begin m_cnt = 0; done = 1; end
            end
            if (done) begin
                if (!m_wv || a) begin
                    m_wo = m_sr; m_wv = 1;
`ifdef STP_PARITY_EN
                    m_perr = (($countones(m_sr[7:0]) % 2) != int'(d));
`endif
                end else m_ovr = 1;
            end else if (m_wv && a) m_wv = 0;
        end
        @(posedge clk); #1;
    endtask

    // Shift w MSB-first into u_dut, then the parity beat if enabled; ack only on the final beat.
    task automatic shift_word(input logic [7:0] w, input bit pbit, input bit ack_last);
        for (int i = 7; i >= 0; i--)
            cycle(0, 0, 1, w[i], (PAR == 0 && i == 0) ? ack_last : 1'b0, 0, 2'b00);
        if (PAR != 0) cycle(0, 0, 1, pbit, ack_last, 0, 2'b00);
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0, 0, 2'b00);
        cycle(1, 0, 1, 0, 1, 1, 2'b00);
        checks += 7;
        if (po !== 8'hFF) begin errors++; $display("FAIL reset_po got %h exp ff", po); end
        if (fc !== 4'd0)  begin errors++; $display("FAIL reset_fc got %0d exp 0", fc); end
        if (wo !== 8'h00) begin errors++; $display("FAIL reset_wo got %h exp 00", wo); end
        if (wv !== 1'b0)  begin errors++; $display("FAIL reset_wv got %b exp 0", wv); end
        if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", ovr); end
        if (po2 !== 8'hFF) begin errors++; $display("FAIL reset_po2 got %h exp ff", po2); end
        if (ovr2 !== 1'b0) begin errors++; $display("FAIL reset_ovr2 got %b exp 0", ovr2); end
    endtask

    task automatic test_msb_word();
        logic [7:0] bits = 8'b1011_0010;
        for (int i = 7; i >= 1; i--) cycle(0, 0, 1, bits[i], 0, 0, 2'b00);
        checks += 2;
        if (wv !== 1'b0) begin errors++; $display("FAIL msb_early_wv got %b exp 0", wv); end
        if (fc !== 4'd7) begin errors++; $display("FAIL msb_fc7 got %0d exp 7", fc); end
        cycle(0, 0, 1, bits[0], 0, 0, 2'b00);
        if (PAR != 0) cycle(0, 0, 1, 1'b0, 0, 0, 2'b00);
        checks += 3;
        if (wv !== 1'b1)  begin errors++; $display("FAIL msb_wv got %b exp 1", wv); end
        if (wo !== 8'hB2) begin errors++; $display("FAIL msb_wo got %h exp b2", wo); end
        if (fc !== 4'd0)  begin errors++; $display("FAIL msb_fc_wrap got %0d exp 0", fc); end
    endtask

    task automatic test_lsb_lanes();
        logic [1:0] lanes [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        for (int i = 0; i < F2; i++) begin
            cycle(0, 0, 0, 0, 0, 1, (i < B2) ? lanes[i] : 2'b00);
            checks++;
            if (fc2 !== 3'((i + 1) % F2)) begin
                errors++; $display("FAIL lsb_fc beat %0d got %0d exp %0d", i, fc2, (i + 1) % F2);
            end
        end
        checks += 2;
        if (wo2 !== 8'h39) begin errors++; $display("FAIL lsb_wo got %h exp 39", wo2); end
        if (wv2 !== 1'b1)  begin errors++; $display("FAIL lsb_wv got %b exp 1", wv2); end
    endtask

    task automatic test_overrun_clear();
        shift_word(8'h5A, 1'b0, 1'b0);
        checks += 3;
        if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", ovr); end
        if (wo !== 8'hB2) begin errors++; $display("FAIL ovr_wo got %h exp b2", wo); end
        if (po !== 8'h5A) begin errors++; $display("FAIL ovr_po got %h exp 5a", po); end
        cycle(0, 1, 1, 1, 1, 0, 2'b00);
        checks += 5;
        if (ovr !== 1'b0) begin errors++; $display("FAIL clr_ovr got %b exp 0", ovr); end
        if (wv !== 1'b0)  begin errors++; $display("FAIL clr_wv got %b exp 0", wv); end
        if (fc !== 4'd0)  begin errors++; $display("FAIL clr_fc got %0d exp 0", fc); end
        if (po !== 8'hFF) begin errors++; $display("FAIL clr_po got %h exp ff", po); end
        if (wo !== 8'hB2) begin errors++; $display("FAIL clr_wo_held got %h exp b2", wo); end
    endtask

    task automatic test_ack_same_cycle();
        shift_word(8'h3C, 1'b0, 1'b0);
        shift_word(8'hC3, 1'b0, 1'b1);
        checks += 3;
        if (wv !== 1'b1)  begin errors++; $display("FAIL ackfin_wv got %b exp 1", wv); end
        if (wo !== 8'hC3) begin errors++; $display("FAIL ackfin_wo got %h exp c3", wo); end
        if (ovr !== 1'b0) begin errors++; $display("FAIL ackfin_ovr got %b exp 0", ovr); end
        cycle(0, 0, 0, 0, 1, 0, 2'b00);
        checks += 2;
        if (wv !== 1'b0)  begin errors++; $display("FAIL ack_wv got %b exp 0", wv); end
        if (wo !== 8'hC3) begin errors++; $display("FAIL ack_wo_hold got %h exp c3", wo); end
    endtask

    task automatic test_reset_midword();
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1'b0, 0, 0, 2'b00);
        cycle(1, 0, 0, 0, 0, 0, 2'b00);
        checks += 2;
        if (fc !== 4'd0)  begin errors++; $display("FAIL midrst_fc got %0d exp 0", fc); end
        if (po !== 8'hFF) begin errors++; $display("FAIL midrst_po got %h exp ff", po); end
        shift_word(8'h96, 1'b0, 1'b0);
        checks += 2;
        if (wo !== 8'h96) begin errors++; $display("FAIL midrst_wo got %h exp 96", wo); end
        if (wv !== 1'b1)  begin errors++; $display("FAIL midrst_wv got %b exp 1", wv); end
    endtask

`ifdef STP_PARITY_EN
    task automatic test_parity();
        cycle(1, 0, 0, 0, 0, 0, 2'b00);
        shift_word(8'hB2, 1'b0, 1'b0);
        checks++;
        if (perr !== 1'b0) begin errors++; $display("FAIL par_ok got %b exp 0", perr); end
        cycle(0, 0, 0, 0, 1, 0, 2'b00);
        shift_word(8'hB2, 1'b1, 1'b0);
        checks++;
        if (perr !== 1'b1) begin errors++; $display("FAIL par_bad got %b exp 1", perr); end
    endtask
`endif

    task automatic test_random();
        cycle(1, 0, 0, 0, 0, 0, 2'b00);
        for (int n = 0; n < 600; n++) begin
            cycle(0, ($urandom_range(0, 80) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), ($urandom_range(0, 5) == 0), 0, 2'b00);
            checks += 5;
            if (po !== 8'(m_sr))  begin errors++; $display("FAIL rnd_po @%0d got %h exp %h", n, po, 8'(m_sr)); end
            if (fc !== 4'(m_cnt)) begin errors++; $display("FAIL rnd_fc @%0d got %0d exp %0d", n, fc, m_cnt); end
            if (wo !== 8'(m_wo))  begin errors++; $display("FAIL rnd_wo @%0d got %h exp %h", n, wo, 8'(m_wo)); end
            if (wv !== m_wv)      begin errors++; $display("FAIL rnd_wv @%0d got %b exp %b", n, wv, m_wv); end
            if (ovr !== m_ovr)    begin errors++; $display("FAIL rnd_ovr @%0d got %b exp %b", n, ovr, m_ovr); end
`ifdef STP_PARITY_EN
            checks++;
            if (perr !== m_perr)  begin errors++; $display("FAIL rnd_perr @%0d got %b exp %b", n, perr, m_perr); end
`endif
        end
    endtask

    initial begin
        rst = 1; clear = 0; se = 0; sin = 0; ack = 0; se2 = 0; sin2 = 0;
        #1;
        test_reset();
        test_msb_word();
        test_lsb_lanes();
        test_overrun_clear();
        test_ack_same_cycle();
        test_reset_midword();
`ifdef STP_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
